// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory and its loader.
package imem_pkg;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        RUN,
        ERR
    } imem_state_t;

    localparam int IMEM_WORD_BITS = 32;
    localparam int LOAD_BYTE_BITS = 8;

endpackage

// File: rtl/imem_loader_bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
// The read register holds when re is low and clears on reset.
module bram_sdp #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    (* ram_style = "block" *)
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a length-prefixed byte-stream loader
// and a stallable single-cycle fetch port.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS) + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_valid,
    input  logic [LOAD_BYTE_BITS-1:0] load_byte,
    output logic                      load_ready,
    output logic                      loaded,
    output logic                      load_error,
    input  logic                      fetch_req,
    input  logic                      fetch_stall,
    input  logic [ADDR_WIDTH-1:0]     fetch_addr,
    output logic [IMEM_WORD_BITS-1:0] fetch_data,
    output logic                      fetch_valid,
    output logic                      fetch_misaligned
);

    localparam int WIDX = ADDR_WIDTH - 2;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    imem_state_t state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] buf_q, buf_d;
    logic [WIDX-1:0] word_cnt_q, word_cnt_d;
    logic [31:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;

    logic        accept;
    logic        last_byte;
    logic [31:0] assembled;
    logic        we;
    logic        re;

    assign load_ready = (state_q == HDR) || (state_q == DATA);
    assign loaded     = (state_q == RUN);
    assign load_error = (state_q == ERR);
    assign accept     = load_valid && load_ready;
    assign last_byte  = accept && (byte_cnt_q == 2'd3);
    // First byte of a group ends up in bits 7:0.
    assign assembled  = {load_byte, buf_q};
    assign re         = (state_q == RUN) && fetch_req && !fetch_stall;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        word_cnt_d = word_cnt_q;
        count_d    = count_q;
        valid_d    = valid_q;
        mis_d      = mis_q;
        we         = 1'b0;

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            buf_d      = {load_byte, buf_q[23:8]};
        end

        unique case (state_q)
            HDR: begin
                if (last_byte) begin
                    count_d = assembled;
                    if (assembled == 32'd0) begin
                        state_d = RUN;
                    end else if (assembled > DEPTH_L) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_byte) begin
                    we         = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (32'(word_cnt_q) == count_q - 32'd1) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!fetch_stall) begin
                    valid_d = fetch_req;
                    mis_d   = fetch_req && (|fetch_addr[1:0]);
                end
            end
            ERR: begin
                valid_d = 1'b0;
                mis_d   = 1'b0;
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HDR;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            word_cnt_q <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            word_cnt_q <= word_cnt_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            mis_q      <= mis_d;
        end
    end

    bram_sdp #(
        .DEPTH(DEPTH_WORDS),
        .WIDTH(IMEM_WORD_BITS)
    ) u_ram (
        .clk  (clk),
        .rst  (reset),
        .we   (we),
        .waddr(word_cnt_q),
        .wdata(assembled),
        .re   (re),
        .raddr(fetch_addr[ADDR_WIDTH-1:2]),
        .rdata(fetch_data)
    );

    assign fetch_valid      = valid_q;
    assign fetch_misaligned = mis_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed load/fetch sequences, a fetch vector
// table, and a randomized load + fetch run against a stream-level model.
module tb_imem_loader;

    localparam int DEPTH = 4096;
    localparam int AW = $clog2(DEPTH) + 2;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic          req;
        logic          stall;
        logic [AW-1:0] addr;
        logic          ev;
        logic [31:0]   ed;
        logic          em;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_ready;
    logic          loaded;
    logic          load_error;
    logic          fetch_req;
    logic          fetch_stall;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_data;
    logic          fetch_valid;
    logic          fetch_misaligned;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] mem_m [DEPTH];

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_valid      (load_valid),
        .load_byte       (load_byte),
        .load_ready      (load_ready),
        .loaded          (loaded),
        .load_error      (load_error),
        .fetch_req       (fetch_req),
        .fetch_stall     (fetch_stall),
        .fetch_addr      (fetch_addr),
        .fetch_data      (fetch_data),
        .fetch_valid     (fetch_valid),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_byte   = 8'h00;
        fetch_req   = 1'b0;
        fetch_stall = 1'b0;
        fetch_addr  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    // Applies a byte stream to the model: header N, then every complete
    // group of 4 bytes up to N words, little-endian, from word 0.
    task automatic model_load(input bq_t q);
        int n;
        if (q.size() < 4) return;
        n = int'({q[3], q[2], q[1], q[0]});
        if (n > DEPTH) return;
        for (int i = 0; i < n; i++) begin
            if (4 * i + 7 < q.size()) begin
                mem_m[i] = {q[4*i+7], q[4*i+6], q[4*i+5], q[4*i+4]};
            end
        end
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        bq_t q;
        logic        ev;
        logic [31:0] ed;
        logic        em;
        int          w;

        tbl[0] = '{1'b1, 1'b0, AW'(0), 1'b1, 32'h00000013, 1'b0};
        tbl[1] = '{1'b1, 1'b0, AW'(4), 1'b1, 32'h00100093, 1'b0};
        tbl[2] = '{1'b1, 1'b1, AW'(0), 1'b1, 32'h00100093, 1'b0};
        tbl[3] = '{1'b0, 1'b1, AW'(8), 1'b1, 32'h00100093, 1'b0};
        tbl[4] = '{1'b1, 1'b1, AW'(0), 1'b1, 32'h00100093, 1'b0};
        tbl[5] = '{1'b1, 1'b0, AW'(6), 1'b1, 32'h00100093, 1'b1};
        tbl[6] = '{1'b0, 1'b0, AW'(0), 1'b0, 32'h00100093, 1'b0};
        tbl[7] = '{1'b1, 1'b1, AW'(0), 1'b0, 32'h00100093, 1'b0};
        tbl[8] = '{1'b1, 1'b0, AW'(1), 1'b1, 32'h00000013, 1'b1};
        tbl[9] = '{1'b1, 1'b1, AW'(4), 1'b1, 32'h00000013, 1'b1};

        do_reset();
        check("rst_fetch_data", fetch_data, 32'h0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_mis", 32'(fetch_misaligned), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);

        // N=2 program
        q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 11; i++) send(q[i]);
        check("n2_loaded_before_last", 32'(loaded), 32'd0);
        send(q[11]);
        check("n2_loaded", 32'(loaded), 32'd1);
        check("n2_ready_low", 32'(load_ready), 32'd0);
        model_load(q);

        for (int i = 0; i < 10; i++) begin
            fetch_req   = tbl[i].req;
            fetch_stall = tbl[i].stall;
            fetch_addr  = tbl[i].addr;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(fetch_valid),
                  32'(tbl[i].ev));
            check($sformatf("vec%0d_data", i), fetch_data, tbl[i].ed);
            check($sformatf("vec%0d_mis", i), 32'(fetch_misaligned),
                  32'(tbl[i].em));
        end
        fetch_req   = 1'b0;
        fetch_stall = 1'b0;

        // Empty program
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h00);
        check("n0_loaded_before", 32'(loaded), 32'd0);
        send(8'h00);
        check("n0_loaded", 32'(loaded), 32'd1);

        // Oversized header
        do_reset();
        send(8'h01);
        send(8'h10);
        send(8'h00);
        send(8'h00);
        check("err_flag", 32'(load_error), 32'd1);
        check("err_ready", 32'(load_ready), 32'd0);
        check("err_loaded", 32'(loaded), 32'd0);
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_no_fetch", 32'(fetch_valid), 32'd0);
        end
        fetch_req = 1'b0;
        send(8'h55);
        check("err_sticky", 32'(load_error), 32'd1);

        // Reset mid-load, then reload one word
        do_reset();
        q = {8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        foreach (q[i]) send(q[i]);
        model_load(q);
        do_reset();
        check("midrst_loaded", 32'(loaded), 32'd0);
        check("midrst_ready", 32'(load_ready), 32'd1);
        q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (q[i]) send(q[i]);
        model_load(q);
        check("reload_loaded", 32'(loaded), 32'd1);
        fetch(AW'(0));
        check("reload_w0", fetch_data, 32'h12345678);
        fetch(AW'(4));
        check("reload_w1_kept", fetch_data, 32'h00100093);

        // Random 64-word load with gaps
        do_reset();
        q = {8'd64, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        for (int i = 0; i < q.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                load_byte = 8'($urandom);
                tick();
            end
            if (i == q.size() - 1) begin
                check("rnd_loaded_before", 32'(loaded), 32'd0);
                check("rnd_ready_before", 32'(load_ready), 32'd1);
            end
            send(q[i]);
        end
        model_load(q);
        check("rnd_loaded", 32'(loaded), 32'd1);
        for (int i = 0; i < 16; i++) send(8'($urandom));
        check("rnd_ready_run", 32'(load_ready), 32'd0);

        // Random fetch traffic against rule-level expectations
        ev = 1'b0;
        ed = 32'h0;
        em = 1'b0;
        for (int i = 0; i < 64; i++) begin
            fetch(AW'(i * 4));
            check($sformatf("rnd_word%0d", i), fetch_data, mem_m[i]);
        end
        ev = 1'b0;
        ed = mem_m[63];
        em = 1'b0;
        fetch_req = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) begin
            w           = $urandom_range(0, 63);
            fetch_req   = ($urandom_range(0, 3) != 0);
            fetch_stall = ($urandom_range(0, 3) == 0);
            fetch_addr  = AW'(w * 4 + $urandom_range(0, 3));
            if (!fetch_stall) begin
                ev = fetch_req;
                em = fetch_req && (fetch_addr[1:0] != 2'b00);
                if (fetch_req) ed = mem_m[w];
            end
            tick();
            check("rand_valid", 32'(fetch_valid), 32'(ev));
            check("rand_data", fetch_data, ed);
            check("rand_mis", 32'(fetch_misaligned), 32'(em));
        end
        fetch_req   = 1'b0;
        fetch_stall = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory with a built-in byte-stream program loader and a stallable fetch port. After reset it accepts a length-prefixed little-endian byte stream (typically from the UART receiver) and writes it into block RAM from word 0. It then switches to run mode and serves 1-cycle-latency word fetches to the CPU front end. The pipeline can freeze the fetch output with a stall.

## Interface
- DEPTH_WORDS, 4096: memory depth in 32-bit words; power of two, at least 2.
- ADDR_WIDTH, derived localparam = $clog2(DEPTH_WORDS)+2: byte-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  loader byte present.
- load_byte  in  8  loader byte.
- load_ready  out  1  loader can accept a byte (states HDR, DATA).
- loaded  out  1  program load complete (state RUN).
- load_error  out  1  header count exceeded DEPTH_WORDS (state ERR, sticky until reset).
- fetch_req  in  1  fetch request.
- fetch_stall  in  1  freeze fetch output.
- fetch_addr  in  ADDR_WIDTH  byte address.
- fetch_data  out  32  fetched instruction.
- fetch_valid  out  1  fetch_data is valid.
- fetch_misaligned  out  1  the returned fetch had fetch_addr[1:0] != 0.

## Operation
- States: HDR, DATA, RUN, ERR. Reset sets the state to HDR and clears the byte counter, word counter, count register and fetch outputs. Memory contents are not cleared.
- Byte acceptance: a byte is accepted on an edge where load_valid && load_ready.
- HDR: collects 4 bytes little-endian into the 32-bit count N. On the 4th byte:
  - N == 0 -> RUN.
  - N > DEPTH_WORDS -> ERR.
  - otherwise -> DATA.
- DATA: every 4 accepted bytes form one little-endian word (first byte = bits 7:0).
  - The word is written at word index = word counter on the same edge that accepts its 4th byte. The word counter then increments.
  - The edge that writes word N-1 moves the state to RUN.
- RUN: load_valid is ignored and load_ready = 0. Fetch is enabled.
- ERR: no loading and no fetching. load_error = 1.
- Read enable = RUN && fetch_req && !fetch_stall. Read word index = fetch_addr[ADDR_WIDTH-1:2]. The low 2 bits are ignored for data selection.
- On an enabled edge:
  - fetch_data is loaded from memory.
  - fetch_valid <= 1.
  - fetch_misaligned <= |fetch_addr[1:0].
- Edge with RUN && !fetch_stall && !fetch_req: fetch_valid <= 0, fetch_misaligned <= 0. fetch_data holds.
- Any edge with fetch_stall = 1: fetch_data, fetch_valid and fetch_misaligned all hold.
- Outside RUN: fetch_valid = 0.

## Timing
- Reset values: fetch_data 0, fetch_valid 0, fetch_misaligned 0, loaded 0, load_error 0, load_ready 1 (HDR).
- Load latency: loaded rises on the cycle after the edge accepting the final byte. Total = 4 + 4N accepted bytes.
- Fetch latency: request sampled at edge t -> data and valid present from edge t+1.
- Back-to-back requests without stall give one word per cycle.
- Stall asserted together with fetch_req: the request is dropped. The front end re-presents it.
- A read of a word index written on the same edge cannot occur, because fetch is only enabled in RUN.
- Reset mid-load or mid-run returns to HDR on that edge. Partially written words remain in RAM; no partial word is written.
- Loader bytes arriving without load_valid, or in RUN/ERR, never touch counters or memory.

## Structure
- Shared package imem_pkg holds:
  - typedef enum logic [1:0] imem_state_t {HDR, DATA, RUN, ERR};
  - constants IMEM_WORD_BITS = 32 and LOAD_BYTE_BITS = 8.
- One sub-module, bram_sdp: simple dual-port block RAM (ram_style BLOCK).
  - Ports: one write port (we, waddr, wdata).
  - One read port (re, raddr) with registered output that holds when re = 0.
  - Parameters: DEPTH and WIDTH.
- The top level contains the FSM, byte assembler (3 buffered bytes + 2-bit byte counter), word counter, count register and fetch flags.

## Test plan
- Load N=2, bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> loaded high after 12th byte. Fetch 0x0 -> 0x00000013. Fetch 0x4 -> 0x00100093, each valid one cycle after request.
- Header 00 00 00 00 -> RUN after 4th byte. Header 01 10 00 00 (N=4097, DEPTH 4096) -> load_error=1, load_ready=0, fetch_req produces no fetch_valid.
- In RUN, request 0x4 then raise fetch_stall for 3 cycles while changing fetch_addr -> fetch_data stays 0x00100093 and fetch_valid stays 1 throughout.
- Fetch 0x6 -> data = word 1, fetch_misaligned=1. A following cycle with no request -> fetch_valid=0, fetch_misaligned=0.
- Assert reset after 6 loader bytes, then reload N=1 with 78 56 34 12 -> word 0 = 0x12345678. Word 1 retains its previously loaded contents.
- Randomly gap load_valid during a 64-word load; compare all words against the model. Bytes offered while load_ready=0 are ignored.
